// File: rtl/evm_pkg.sv
// Shared definitions for the EVM vote-tally back end: party codes,
// tally FSM state encoding and the default per-party counter width.
package evm_pkg;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned NUM_PARTIES = 4;
  localparam int unsigned PARTY_W     = 2;

  typedef logic [PARTY_W-1:0] party_t;

  localparam party_t PARTY_1 = 2'b00;
  localparam party_t PARTY_2 = 2'b01;
  localparam party_t PARTY_3 = 2'b10;
  localparam party_t PARTY_4 = 2'b11;

  typedef enum logic [1:0] {
    ST_COUNT = 2'b00,
    ST_SCAN  = 2'b01,
    ST_DONE  = 2'b10
  } tally_state_e;

endpackage

// File: rtl/evm_party_counter.sv
// Saturating per-party vote counter.
//   clk, reset   : clock, async active-high reset
//   inc          : add one vote (ignored when saturated)
//   clr          : zero the counter (wins over inc)
//   count        : registered tally
//   count_nxt_c  : value count takes at the next edge (combinational)
//   sat_hit_c    : inc arrived while the counter was already saturated
module evm_party_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             sat_hit_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Next-value and saturation detect
  always_comb begin
    count_nxt_c = count;
    sat_hit_c   = 1'b0;
    if (clr) begin
      count_nxt_c = '0;
    end else if (inc) begin
      if (count == CNT_MAX) begin
        sat_hit_c = 1'b1;
      end else begin
        count_nxt_c = count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/evm_vote_tally.sv
// EVM vote-accumulation back end. Counts one-cycle party-vote strobes into
// four saturating counters, plays the tallies out serially on request and
// then reports the winning party.
//   clk, reset                 : clock, async active-high reset
//   vote_valid, vote_party     : one vote strobe for the given party
//   tally_clear                : zero all tallies (COUNT only)
//   result_req                 : start the four-word playout
//   vote_ack / vote_reject     : registered per-vote accept/drop pulse
//   result_busy                : playout or winner cycle in progress
//   result_valid/party/count   : one playout word per cycle
//   winner_valid/party/tie     : winner after playout
//   total_votes                : sum of counted votes
//   overflow                   : sticky, a vote hit a saturated counter
module evm_vote_tally
  import evm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vote_valid,
  input  logic [1:0]         vote_party,
  input  logic               tally_clear,
  input  logic               result_req,
  output logic               vote_ack,
  output logic               vote_reject,
  output logic               result_busy,
  output logic               result_valid,
  output logic [1:0]         result_party,
  output logic [CNT_W-1:0]   result_count,
  output logic               winner_valid,
  output logic [1:0]         winner_party,
  output logic               winner_tie,
  output logic [CNT_W+1:0]   total_votes,
  output logic               overflow
);

  localparam int unsigned TOT_W = CNT_W + 2;

  tally_state_e state, state_nxt;

  party_t           scan_idx, scan_idx_nxt;
  logic [CNT_W-1:0] max_cnt, max_cnt_nxt;
  party_t           arg_party, arg_party_nxt;
  logic             tie_flag, tie_flag_nxt;

  logic [NUM_PARTIES-1:0] inc;
  logic [NUM_PARTIES-1:0] sat_hit;
  logic [CNT_W-1:0]       cnt     [NUM_PARTIES];
  logic [CNT_W-1:0]       cnt_nxt [NUM_PARTIES];

  logic vote_take;
  logic clr;

  logic             vote_ack_nxt, vote_reject_nxt;
  logic             result_busy_nxt, result_valid_nxt;
  party_t           result_party_nxt;
  logic [CNT_W-1:0] result_count_nxt;
  logic             winner_valid_nxt, winner_tie_nxt;
  party_t           winner_party_nxt;
  logic [TOT_W-1:0] total_nxt;
  logic             overflow_nxt;

  // Votes are only taken in COUNT; a clear in the same cycle drops the vote
  assign vote_take = (state == ST_COUNT) && vote_valid && !tally_clear;
  assign clr       = (state == ST_COUNT) && tally_clear;

  for (genvar g = 0; g < NUM_PARTIES; g++) begin : g_party
    assign inc[g] = vote_take && (vote_party == PARTY_W'(g));

    evm_party_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .inc         (inc[g]),
      .clr         (clr),
      .count       (cnt[g]),
      .count_nxt_c (cnt_nxt[g]),
      .sat_hit_c   (sat_hit[g])
    );
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt        = state;
    scan_idx_nxt     = scan_idx;
    max_cnt_nxt      = max_cnt;
    arg_party_nxt    = arg_party;
    tie_flag_nxt     = tie_flag;
    vote_ack_nxt     = vote_take;
    vote_reject_nxt  = vote_valid && !vote_take;
    result_valid_nxt = 1'b0;
    result_party_nxt = '0;
    result_count_nxt = '0;
    winner_valid_nxt = winner_valid;
    winner_party_nxt = winner_party;
    winner_tie_nxt   = winner_tie;
    total_nxt        = total_votes;
    overflow_nxt     = overflow | (|sat_hit);

    case (state)
      ST_COUNT: begin
        if (clr) begin
          total_nxt = '0;
        end else if (vote_take && !(|sat_hit)) begin
          total_nxt = total_votes + TOT_W'(1);
        end
        if (vote_take || clr || result_req) begin
          winner_valid_nxt = 1'b0;
        end
        // Word 0 uses the post-edge count so a same-cycle vote is included
        if (result_req) begin
          state_nxt        = ST_SCAN;
          scan_idx_nxt     = PARTY_1;
          result_valid_nxt = 1'b1;
          result_party_nxt = PARTY_1;
          result_count_nxt = cnt_nxt[0];
          max_cnt_nxt      = cnt_nxt[0];
          arg_party_nxt    = PARTY_1;
          tie_flag_nxt     = 1'b0;
        end
      end

      ST_SCAN: begin
        if (scan_idx == PARTY_4) begin
          state_nxt        = ST_DONE;
          winner_valid_nxt = 1'b1;
          winner_party_nxt = arg_party;
          winner_tie_nxt   = tie_flag;
        end else begin
          // Strict greater-than keeps the lowest code on a tie
          scan_idx_nxt     = scan_idx + PARTY_W'(1);
          result_valid_nxt = 1'b1;
          result_party_nxt = scan_idx_nxt;
          result_count_nxt = cnt[scan_idx_nxt];
          if (cnt[scan_idx_nxt] > max_cnt) begin
            max_cnt_nxt   = cnt[scan_idx_nxt];
            arg_party_nxt = scan_idx_nxt;
            tie_flag_nxt  = 1'b0;
          end else if (cnt[scan_idx_nxt] == max_cnt) begin
            tie_flag_nxt  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_COUNT;
      end

      default: begin
        state_nxt = ST_COUNT;
      end
    endcase

    result_busy_nxt = (state_nxt != ST_COUNT);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_COUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx     <= '0;
      max_cnt      <= '0;
      arg_party    <= '0;
      tie_flag     <= 1'b0;
      vote_ack     <= 1'b0;
      vote_reject  <= 1'b0;
      result_busy  <= 1'b0;
      result_valid <= 1'b0;
      result_party <= '0;
      result_count <= '0;
      winner_valid <= 1'b0;
      winner_party <= '0;
      winner_tie   <= 1'b0;
      total_votes  <= '0;
      overflow     <= 1'b0;
    end else begin
      scan_idx     <= scan_idx_nxt;
      max_cnt      <= max_cnt_nxt;
      arg_party    <= arg_party_nxt;
      tie_flag     <= tie_flag_nxt;
      vote_ack     <= vote_ack_nxt;
      vote_reject  <= vote_reject_nxt;
      result_busy  <= result_busy_nxt;
      result_valid <= result_valid_nxt;
      result_party <= result_party_nxt;
      result_count <= result_count_nxt;
      winner_valid <= winner_valid_nxt;
      winner_party <= winner_party_nxt;
      winner_tie   <= winner_tie_nxt;
      total_votes  <= total_nxt;
      overflow     <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_evm_vote_tally.sv
// Self-checking bench for evm_vote_tally: an 8-bit instance exercised with
// directed and randomized vote streams against a tally model, plus a 2-bit
// instance for saturation.
module tb_evm_vote_tally;

  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  // 8-bit instance
  logic          vote_valid = 1'b0;
  logic [1:0]    vote_party = 2'b00;
  logic          tally_clear = 1'b0;
  logic          result_req = 1'b0;
  logic          vote_ack, vote_reject, result_busy, result_valid;
  logic [1:0]    result_party;
  logic [CW-1:0] result_count;
  logic          winner_valid;
  logic [1:0]    winner_party;
  logic          winner_tie;
  logic [CW+1:0] total_votes;
  logic          overflow;

  // 2-bit instance
  logic       d2_vote_valid = 1'b0;
  logic [1:0] d2_vote_party = 2'b00;
  logic       d2_tally_clear = 1'b0;
  logic       d2_result_req = 1'b0;
  logic       d2_vote_ack, d2_vote_reject, d2_result_busy, d2_result_valid;
  logic [1:0] d2_result_party;
  logic [1:0] d2_result_count;
  logic       d2_winner_valid;
  logic [1:0] d2_winner_party;
  logic       d2_winner_tie;
  logic [3:0] d2_total_votes;
  logic       d2_overflow;

  evm_vote_tally #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .vote_valid(vote_valid), .vote_party(vote_party),
    .tally_clear(tally_clear), .result_req(result_req),
    .vote_ack(vote_ack), .vote_reject(vote_reject),
    .result_busy(result_busy), .result_valid(result_valid),
    .result_party(result_party), .result_count(result_count),
    .winner_valid(winner_valid), .winner_party(winner_party),
    .winner_tie(winner_tie), .total_votes(total_votes), .overflow(overflow)
  );

  evm_vote_tally #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .vote_valid(d2_vote_valid), .vote_party(d2_vote_party),
    .tally_clear(d2_tally_clear), .result_req(d2_result_req),
    .vote_ack(d2_vote_ack), .vote_reject(d2_vote_reject),
    .result_busy(d2_result_busy), .result_valid(d2_result_valid),
    .result_party(d2_result_party), .result_count(d2_result_count),
    .winner_valid(d2_winner_valid), .winner_party(d2_winner_party),
    .winner_tie(d2_winner_tie), .total_votes(d2_total_votes), .overflow(d2_overflow)
  );

  wire [28:0] all_out = {vote_ack, vote_reject, result_busy, result_valid, result_party,
                         result_count, winner_valid, winner_party, winner_tie,
                         total_votes, overflow};

  int checks = 0;
  int failures = 0;

  // Reference model: plain per-party vote totals
  int m_cnt [4];
  int m_total;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int p = 0; p < 4; p++) m_cnt[p] = 0;
    m_total = 0;
  endtask

  // Winner: highest tally, lowest code among equals, tie if shared
  function automatic void model_winner(output logic [1:0] wp, output logic wt);
    int best = -1;
    int n = 0;
    wp = 2'b00;
    for (int p = 0; p < 4; p++) if (m_cnt[p] > best) best = m_cnt[p];
    for (int p = 3; p >= 0; p--) if (m_cnt[p] == best) begin n++; wp = 2'(p); end
    wt = (n > 1);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_out !== 29'd0) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    checks++;
    if ({d2_overflow, d2_total_votes, d2_vote_ack} !== 6'd0) begin
      failures++; $display("FAIL reset_outputs_w2: got ovf=%0b total=%0d", d2_overflow, d2_total_votes);
    end
    reset = 1'b0;
    model_clear();
    step();
  endtask

  // mode 0: 3x01 + 1x11; mode 1: 2x10 + 2x11; mode 2: empty; else random
  task automatic test_tally(input int mode);
    int q[$];
    logic [1:0] wp;
    logic wt;
    logic nv;
    bit noisy;
    noisy = (mode >= 3);
    tally_clear = 1'b1; step(); tally_clear = 1'b0;
    model_clear();
    checks++;
    if (total_votes !== 10'd0 || winner_valid !== 1'b0) begin
      failures++; $display("FAIL clear: got total=%0d wv=%0b want 0 0", total_votes, winner_valid);
    end
    case (mode)
      0: q = '{1, 1, 1, 3};
      1: q = '{2, 2, 3, 3};
      2: q = {};
      default: begin
        int n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 3));
      end
    endcase
    foreach (q[i]) begin
      vote_valid = 1'b1; vote_party = 2'(q[i]);
      step();
      vote_valid = 1'b0;
      m_cnt[q[i]]++; m_total++;
      checks++;
      if (vote_ack !== 1'b1 || vote_reject !== 1'b0 || total_votes !== 10'(m_total)) begin
        failures++;
        $display("FAIL vote_accept: got ack=%0b rej=%0b total=%0d want 1 0 %0d",
                 vote_ack, vote_reject, total_votes, m_total);
      end
      if (noisy && $urandom_range(0, 1) == 1) begin
        step();
        checks++;
        if (vote_ack !== 1'b0) begin
          failures++; $display("FAIL idle_ack: got %0b want 0", vote_ack);
        end
      end
    end
    result_req = 1'b1; step(); result_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (result_busy !== 1'b1 || result_valid !== 1'b1 || result_party !== 2'(k) ||
          result_count !== CW'(m_cnt[k])) begin
        failures++;
        $display("FAIL playout_word%0d: got busy=%0b v=%0b p=%0d c=%0d want 1 1 %0d %0d",
                 k, result_busy, result_valid, result_party, result_count, k, m_cnt[k]);
      end
      nv = 1'b0;
      if (noisy) begin
        nv = 1'($urandom_range(0, 1));
        vote_valid = nv; vote_party = 2'($urandom);
        tally_clear = 1'($urandom_range(0, 1)); result_req = 1'($urandom_range(0, 1));
      end
      step();
      vote_valid = 1'b0; tally_clear = 1'b0; result_req = 1'b0;
      if (noisy) begin
        checks++;
        if (vote_reject !== nv || vote_ack !== 1'b0) begin
          failures++; $display("FAIL scan_reject: got rej=%0b ack=%0b want %0b 0", vote_reject, vote_ack, nv);
        end
      end
    end
    model_winner(wp, wt);
    checks++;
    if (winner_valid !== 1'b1 || winner_party !== wp || winner_tie !== wt ||
        result_valid !== 1'b0 || result_party !== 2'd0 || result_count !== '0 ||
        result_busy !== 1'b1 || total_votes !== 10'(m_total)) begin
      failures++;
      $display("FAIL done_winner: got wv=%0b wp=%0d tie=%0b rv=%0b busy=%0b total=%0d want 1 %0d %0b 0 1 %0d",
               winner_valid, winner_party, winner_tie, result_valid, result_busy, total_votes, wp, wt, m_total);
    end
    nv = 1'b0;
    if (noisy) begin
      nv = 1'($urandom_range(0, 1));
      vote_valid = nv; tally_clear = 1'($urandom_range(0, 1)); result_req = 1'($urandom_range(0, 1));
    end
    step();
    vote_valid = 1'b0; tally_clear = 1'b0; result_req = 1'b0;
    checks++;
    if (result_busy !== 1'b0 || winner_valid !== 1'b1 || vote_reject !== nv ||
        total_votes !== 10'(m_total)) begin
      failures++;
      $display("FAIL back_to_count: got busy=%0b wv=%0b rej=%0b total=%0d want 0 1 %0b %0d",
               result_busy, winner_valid, vote_reject, total_votes, nv, m_total);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      d2_vote_valid = 1'b1; d2_vote_party = 2'b00;
      step();
      d2_vote_valid = 1'b0;
      checks++;
      if (d2_vote_ack !== 1'b1 || d2_total_votes !== 4'((i < 3) ? i : 3) ||
          d2_overflow !== 1'(i >= 4)) begin
        failures++;
        $display("FAIL sat_vote%0d: got ack=%0b total=%0d ovf=%0b want 1 %0d %0b",
                 i, d2_vote_ack, d2_total_votes, d2_overflow, (i < 3) ? i : 3, i >= 4);
      end
    end
    d2_result_req = 1'b1; step(); d2_result_req = 1'b0;
    checks++;
    if (d2_result_valid !== 1'b1 || d2_result_party !== 2'd0 || d2_result_count !== 2'd3) begin
      failures++;
      $display("FAIL sat_playout: got v=%0b p=%0d c=%0d want 1 0 3", d2_result_valid, d2_result_party, d2_result_count);
    end
    repeat (5) step();
  endtask

  task automatic test_scan_reject_and_clear();
    tally_clear = 1'b1; step(); tally_clear = 1'b0;
    model_clear();
    vote_valid = 1'b1; vote_party = 2'b10; step(); vote_valid = 1'b0;
    m_cnt[2]++; m_total++;
    result_req = 1'b1; step(); result_req = 1'b0;
    vote_valid = 1'b1; vote_party = 2'b10; step(); vote_valid = 1'b0;
    checks++;
    if (vote_reject !== 1'b1 || vote_ack !== 1'b0 || result_party !== 2'd1) begin
      failures++; $display("FAIL scan_vote: got rej=%0b ack=%0b p=%0d want 1 0 1", vote_reject, vote_ack, result_party);
    end
    step();
    checks++;
    if (result_party !== 2'd2 || result_count !== CW'(m_cnt[2]) || vote_reject !== 1'b0) begin
      failures++; $display("FAIL scan_unchanged: got p=%0d c=%0d rej=%0b want 2 %0d 0", result_party, result_count, vote_reject, m_cnt[2]);
    end
    repeat (3) step();
    vote_valid = 1'b1; vote_party = 2'b01; tally_clear = 1'b1;
    step();
    vote_valid = 1'b0; tally_clear = 1'b0;
    model_clear();
    checks++;
    if (vote_reject !== 1'b1 || vote_ack !== 1'b0 || total_votes !== 10'd0 || winner_valid !== 1'b0) begin
      failures++;
      $display("FAIL vote_with_clear: got rej=%0b ack=%0b total=%0d wv=%0b want 1 0 0 0", vote_reject, vote_ack, total_votes, winner_valid);
    end
  endtask

  task automatic test_vote_with_req();
    tally_clear = 1'b1; step(); tally_clear = 1'b0;
    model_clear();
    vote_valid = 1'b1; vote_party = 2'b00; result_req = 1'b1;
    step();
    vote_valid = 1'b0; result_req = 1'b0;
    checks++;
    if (vote_ack !== 1'b1 || result_valid !== 1'b1 || result_party !== 2'd0 || result_count !== 8'd1) begin
      failures++;
      $display("FAIL vote_req_word0: got ack=%0b v=%0b p=%0d c=%0d want 1 1 0 1", vote_ack, result_valid, result_party, result_count);
    end
    repeat (4) step();
    checks++;
    if (winner_valid !== 1'b1 || winner_party !== 2'd0 || winner_tie !== 1'b0 || total_votes !== 10'd1) begin
      failures++;
      $display("FAIL vote_req_winner: got wv=%0b wp=%0d tie=%0b total=%0d want 1 0 0 1", winner_valid, winner_party, winner_tie, total_votes);
    end
    step();
    vote_valid = 1'b1; vote_party = 2'b11; step(); vote_valid = 1'b0;
    checks++;
    if (winner_valid !== 1'b0 || vote_ack !== 1'b1) begin
      failures++; $display("FAIL winner_hold_clear: got wv=%0b ack=%0b want 0 1", winner_valid, vote_ack);
    end
  endtask

  task automatic test_reset_mid_scan();
    vote_valid = 1'b1; vote_party = 2'b01; step(); vote_valid = 1'b0;
    result_req = 1'b1; step(); result_req = 1'b0;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== 29'd0) begin
      failures++; $display("FAIL reset_mid_scan: got %h want 0", all_out);
    end
    step();
    reset = 1'b0;
    model_clear();
    step();
    checks++;
    if (result_valid !== 1'b0 || winner_valid !== 1'b0 || result_busy !== 1'b0) begin
      failures++; $display("FAIL no_done_after_reset: got v=%0b wv=%0b busy=%0b want 0 0 0", result_valid, winner_valid, result_busy);
    end
    vote_valid = 1'b1; vote_party = 2'b11; step(); vote_valid = 1'b0;
    checks++;
    if (vote_ack !== 1'b1 || total_votes !== 10'd1) begin
      failures++; $display("FAIL vote_after_reset: got ack=%0b total=%0d want 1 1", vote_ack, total_votes);
    end
  endtask

  initial begin
    test_reset();
    test_tally(0);
    test_tally(1);
    test_tally(2);
    test_saturation();
    test_scan_reject_and_clear();
    test_vote_with_req();
    for (int r = 3; r < 15; r++) test_tally(r);
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
